// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_unit: MEM-stage data-memory access engine (RV32I lanes/stall)  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_write_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] mem_load_data,
  output logic        mem_load_valid,
  output logic        mem_fault
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_wstrb_q, dmem_wstrb_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        fault_q, fault_d;

  logic        access, illegal;
  logic [31:0] store_wdata, load_fmt;
  logic [3:0]  store_wstrb;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    access  = mem_MemRead | mem_MemWrite;
    illegal = (mem_MemRead & mem_MemWrite)
            | (mem_MemRead & ((mem_funct3 == 3'b011) | (mem_funct3[2:1] == 2'b11)))
            | (mem_MemWrite & (mem_funct3 > 3'b010))
            | ((mem_funct3[1:0] == 2'b01) & mem_alu_result[0])
            | ((mem_funct3[1:0] == 2'b10) & (mem_alu_result[1:0] != 2'b00));
  end

  // Store data is replicated across lanes so the strobe alone selects the target bytes.
  always_comb begin
    store_wdata = mem_write_data;
    store_wstrb = 4'b1111;
    case (mem_funct3[1:0])
      2'b00: begin
        store_wdata = {4{mem_write_data[7:0]}};
        store_wstrb = 4'b0001 << mem_alu_result[1:0];
      end
      2'b01: begin
        store_wdata = {2{mem_write_data[15:0]}};
        store_wstrb = 4'b0011 << mem_alu_result[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_byte  = dmem_rdata[{addr_lo_q, 3'b000} +: 8];
    rd_half  = addr_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_fmt = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_fmt = {24'd0, rd_byte};
      3'b101:  load_fmt = {16'd0, rd_half};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_wstrb_d = dmem_wstrb_q;
    addr_lo_d    = addr_lo_q;
    funct3_d     = funct3_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    fault_d      = 1'b0;
    mem_stall    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access && illegal) begin
          fault_d = 1'b1;
        end else if (access) begin
          mem_stall    = 1'b1;
          dmem_req_d   = 1'b1;
          dmem_we_d    = mem_MemWrite;
          dmem_addr_d  = {mem_alu_result[31:2], 2'b00};
          dmem_wdata_d = mem_MemWrite ? store_wdata : 32'd0;
          dmem_wstrb_d = mem_MemWrite ? store_wstrb : 4'd0;
          addr_lo_d    = mem_alu_result[1:0];
          funct3_d     = mem_funct3;
          cnt_d        = 8'd0;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_stall = 1'b1;
        if (dmem_ready) begin
          dmem_req_d = 1'b0;
          if (!dmem_we_q) begin
            load_data_d  = load_fmt;
            load_valid_d = 1'b1;
          end
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          dmem_req_d = 1'b0;
          fault_d    = 1'b1;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_wdata_q <= 32'd0;
      dmem_wstrb_q <= 4'd0;
      addr_lo_q    <= 2'd0;
      funct3_q     <= 3'd0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_wstrb_q <= dmem_wstrb_d;
      addr_lo_q    <= addr_lo_d;
      funct3_q     <= funct3_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      fault_q      <= fault_d;
    end
  end

  assign dmem_req       = dmem_req_q;
  assign dmem_we        = dmem_we_q;
  assign dmem_addr      = dmem_addr_q;
  assign dmem_wdata     = dmem_wdata_q;
  assign dmem_wstrb     = dmem_wstrb_q;
  assign mem_load_data  = load_data_q;
  assign mem_load_valid = load_valid_q;
  assign mem_fault      = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_access_unit: directed + random bench against a transaction model  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mem_access_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_MemRead, mem_MemWrite;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result, mem_write_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [31:0] mem_load_data;
  logic        mem_load_valid, mem_fault;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] last_load = 32'd0;

  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result),
    .mem_write_data(mem_write_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_load_data(mem_load_data),
    .mem_load_valid(mem_load_valid), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * a)) & 32'hFF;
    h = a[1] ? (rd >> 16) : (rd & 32'hFFFF);
    case (f3)
      3'b000:  return b - ((b >= 32'd128) ? 32'd256 : 32'd0);
      3'b001:  return h - ((h >= 32'd32768) ? 32'd65536 : 32'd0);
      3'b100:  return b;
      3'b101:  return h;
      default: return rd;
    endcase
  endfunction

  // One instruction presented to the unit; delay >= T means the bus never answers.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int delay);
    logic        ill, timeout, is_load;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    int          n;
    ill = (rd && wr)
       || (rd && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
       || (wr && f3 > 3'b010)
       || ((f3 == 3'b001 || f3 == 3'b101) && addr[0])
       || (f3 == 3'b010 && addr[1:0] != 2'b00);
    e_wstrb = 4'd0;
    e_wdata = wd;
    if (wr && f3 == 3'b000) begin
      e_wdata = (wd & 32'hFF) * 32'h0101_0101;
      e_wstrb = 4'(1 << addr[1:0]);
    end else if (wr && f3 == 3'b001) begin
      e_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
      e_wstrb = 4'(3 << addr[1:0]);
    end else if (wr) begin
      e_wstrb = 4'hF;
    end
    mem_MemRead = rd; mem_MemWrite = wr; mem_funct3 = f3;
    mem_alu_result = addr; mem_write_data = wd; dmem_rdata = rdata;
    dmem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("stall_issue", 32'(mem_stall), 32'(!ill));
    @(posedge clk); #1;
    if (ill) begin
      mem_MemRead = 1'b0; mem_MemWrite = 1'b0; dmem_ready = 1'b0;
      @(negedge clk);
      chk("illegal_fault", 32'(mem_fault), 32'd1);
      chk("illegal_req", 32'(dmem_req), 32'd0);
      chk("illegal_stall", 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
    end else begin
      timeout = (delay >= T);
      is_load = rd;
      n = timeout ? T : delay + 1;
      for (int i = 0; i < n; i++) begin
        dmem_ready = (i == delay);
        @(negedge clk);
        chk("req_high", 32'(dmem_req), 32'd1);
        chk("req_stall", 32'(mem_stall), 32'd1);
        chk("req_addr", dmem_addr, {addr[31:2], 2'b00});
        chk("req_we", 32'(dmem_we), 32'(wr));
        chk("req_wstrb", 32'(dmem_wstrb), 32'(e_wstrb));
        if (wr) chk("req_wdata", dmem_wdata, e_wdata);
        @(posedge clk); #1;
      end
      dmem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("done_stall", 32'(mem_stall), 32'd0);
      chk("done_req", 32'(dmem_req), 32'd0);
      chk("done_fault", 32'(mem_fault), 32'(timeout));
      chk("done_valid", 32'(mem_load_valid), 32'(is_load && !timeout));
      if (is_load && !timeout) last_load = fmt_load(f3, addr[1:0], rdata);
      chk("done_data", mem_load_data, last_load);
      @(posedge clk); #1;
      mem_MemRead = 1'b0; mem_MemWrite = 1'b0; dmem_ready = 1'b0;
    end
    @(negedge clk);
    chk("idle_valid", 32'(mem_load_valid), 32'd0);
    chk("idle_fault", 32'(mem_fault), 32'd0);
    chk("idle_stall", 32'(mem_stall), 32'd0);
    chk("idle_data", mem_load_data, last_load);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] f3_tab [0:7];
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    reset = 1'b1; mem_MemRead = 1'b0; mem_MemWrite = 1'b0; mem_funct3 = 3'd0;
    mem_alu_result = 32'd0; mem_write_data = 32'd0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wstrb", 32'(dmem_wstrb), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_data", mem_load_data, 32'd0);
    chk("rst_valid", 32'(mem_load_valid), 32'd0);
    chk("rst_fault", 32'(mem_fault), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    access(1, 0, 3'b010, 32'h0000_0104, 32'd0, 32'hDEAD_BEEF, 0);
    chk("lw_value", last_load, 32'hDEAD_BEEF);
    access(1, 0, 3'b000, 32'h0000_0203, 32'd0, 32'h8012_3456, 1);
    access(1, 0, 3'b100, 32'h0000_0203, 32'd0, 32'h8012_3456, 2);
    access(1, 0, 3'b101, 32'h0000_0202, 32'd0, 32'h8012_3456, 0);
    access(0, 1, 3'b001, 32'h0000_0302, 32'h1234_ABCD, 32'd0, 0);
    access(1, 0, 3'b010, 32'h0000_0101, 32'd0, 32'd0, 0);
    access(0, 1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'd0, 3);
    access(0, 1, 3'b010, 32'h0000_0404, 32'h0BAD_F00D, 32'd0, 99);
    access(1, 0, 3'b001, 32'h0000_0406, 32'd0, 32'h1234_5678, 99);
    access(1, 1, 3'b010, 32'h0000_0500, 32'd1, 32'd0, 0);
    access(1, 0, 3'b011, 32'h0000_0500, 32'd0, 32'd0, 0);
    access(0, 1, 3'b100, 32'h0000_0500, 32'd7, 32'd0, 0);
    access(0, 1, 3'b001, 32'h0000_0501, 32'd7, 32'd0, 0);
    access(0, 1, 3'b000, 32'h0000_0601, 32'hAABB_CC5A, 32'd0, 1);

    // Reset while the bus request is outstanding abandons the access silently.
    mem_MemRead = 1'b1; mem_MemWrite = 1'b0; mem_funct3 = 3'b010;
    mem_alu_result = 32'h0000_0700; dmem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; mem_MemRead = 1'b0;
    @(negedge clk);
    chk("rstreq_req_before", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstreq_req", 32'(dmem_req), 32'd0);
    chk("rstreq_stall", 32'(mem_stall), 32'd0);
    chk("rstreq_valid", 32'(mem_load_valid), 32'd0);
    last_load = 32'd0;
    @(posedge clk); #1;
    access(1, 0, 3'b010, 32'h0000_0700, 32'd0, 32'h0102_0304, 1);

    for (int k = 0; k < 60; k++) begin
      logic r, w;
      w = 1'($urandom_range(0, 1));
      r = (($urandom_range(0, 9)) == 0) ? 1'b1 : !w;
      access(r, w, f3_tab[$urandom_range(0, ($urandom_range(0, 4) == 0) ? 7 : 4)],
             $urandom, $urandom, $urandom, int'($urandom_range(0, T)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
